// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker
//   Receive-side CRC-8 checker. The last byte of each frame is the transmitted
//   CRC. Data bytes are shifted bit-serially (MSB first, 8 cycles per byte)
//   into an 8-bit CRC register. The CRC register is compared with the trailing
//   byte, and one result is reported per frame.
//   Optional feature macro: CRC_CHK_ERR_CNT_EN. When it is defined, a
//   saturating failed-frame counter is built. When it is undefined, err_count
//   reads as zero.
module crc8_frame_checker #(
   parameter logic [7:0] POLY = 8'h07,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       busy,
   output logic       res_valid,
   output logic       res_ok,
   output logic [7:0] res_len,
   output logic [7:0] res_crc,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_WAIT  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t     r_state;
   logic [7:0] r_crc;
   logic [7:0] r_len;
   logic [7:0] r_byte;
   logic [2:0] r_bit_cnt;
   logic       r_res_valid;
   logic       r_res_ok;
   logic [7:0] r_res_len;
   logic [7:0] r_res_crc;

   logic       w_accept;
   logic       w_fb;
   logic [7:0] w_crc_next;
   logic [7:0] w_len_next;

   // Ready depends only on the registered state, so it never depends on in_valid.
   assign in_ready   = (r_state == S_IDLE) || (r_state == S_WAIT);
   assign busy       = (r_state != S_IDLE);
   assign w_accept   = in_valid && in_ready;

   // One step of the MSB-first, non-reflected CRC-8 shift.
   assign w_fb       = r_crc[7] ^ r_byte[r_bit_cnt];
   assign w_crc_next = {r_crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);

   // The data-byte count sticks at 255 instead of wrapping to 0.
   assign w_len_next = (r_len == 8'hFF) ? r_len : r_len + 8'd1;

   assign res_valid  = r_res_valid;
   assign res_ok     = r_res_ok;
   assign res_len    = r_res_len;
   assign res_crc    = r_res_crc;

`ifdef CRC_CHK_ERR_CNT_EN
   logic [7:0] r_err_count;
   assign err_count = r_err_count;
`else
   assign err_count = 8'h00;
`endif

   // Frame FSM. The result registers are loaded on the edge that accepts the
   // CRC byte, so they are visible in the CHECK cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_crc       <= INIT;
         r_len       <= 8'h00;
         r_byte      <= 8'h00;
         r_bit_cnt   <= 3'd7;
         r_res_valid <= 1'b0;
         r_res_ok    <= 1'b0;
         r_res_len   <= 8'h00;
         r_res_crc   <= 8'h00;
`ifdef CRC_CHK_ERR_CNT_EN
         r_err_count <= 8'h00;
`endif
      end else begin
         // NOTE: non-blocking assignments here. Every branch reads the
         // pre-edge value of r_crc/r_len, whatever order the statements are in.
         r_res_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_WAIT: begin
               if (w_accept) begin
                  r_byte <= in_data;
                  if (in_last) begin
                     // The CRC byte is stored and compared. It is never shifted into the CRC.
                     r_res_valid <= 1'b1;
                     r_res_ok    <= (r_crc == in_data);
                     r_res_crc   <= r_crc;
                     r_res_len   <= r_len;
`ifdef CRC_CHK_ERR_CNT_EN
                     if ((r_crc != in_data) && (r_err_count != 8'hFF))
                        r_err_count <= r_err_count + 8'd1;
`endif
                     r_state     <= S_CHECK;
                  end else begin
                     r_bit_cnt <= 3'd7;
                     r_len     <= w_len_next;
                     r_state   <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_crc <= w_crc_next;
               if (r_bit_cnt == 3'd0)
                  r_state <= S_WAIT;
               else
                  r_bit_cnt <= r_bit_cnt - 3'd1;
            end
            S_CHECK: begin
               r_crc   <= INIT;
               r_len   <= 8'h00;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker
//   Directed bench for crc8_frame_checker. Expected values are CRC-8
//   (polynomial 0x07, initial value 0x00) results that were computed by hand.
//   The expected err_count depends on whether CRC_CHK_ERR_CNT_EN is defined.
module tb_crc8_frame_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       busy;
   logic       res_valid;
   logic       res_ok;
   logic [7:0] res_len;
   logic [7:0] res_crc;
   logic [7:0] err_count;

   int n_checks = 0;
   int n_errors = 0;

`ifdef CRC_CHK_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   crc8_frame_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ok    (res_ok),
      .res_len   (res_len),
      .res_crc   (res_crc),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Hard stop in case the handshake deadlocks somewhere.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and wait (bounded) for acceptance. The task returns in
   // the cycle right after the accepting edge.
   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      check("ready_wait", 8'(in_ready), 8'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int lo;
      rst_n    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_last  = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Reset state.
      check("rst_in_ready",  8'(in_ready),  8'd1);
      check("rst_busy",      8'(busy),      8'd0);
      check("rst_res_valid", 8'(res_valid), 8'd0);
      check("rst_res_ok",    8'(res_ok),    8'd0);
      check("rst_res_len",   res_len,       8'd0);
      check("rst_res_crc",   res_crc,       8'd0);
      check("rst_err_count", err_count,     8'd0);

      // Test 1: "123456789" with the correct CRC 0xF4.
      for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 1'b0);
      send(8'hF4, 1'b1);
      check("t1_res_valid", 8'(res_valid), 8'd1);
      check("t1_res_ok",    8'(res_ok),    8'd1);
      check("t1_res_len",   res_len,       8'd9);
      check("t1_res_crc",   res_crc,       8'hF4);
      check("t1_busy_chk",  8'(busy),      8'd1);
      check("t1_ready_chk", 8'(in_ready),  8'd0);
      step();
      check("t1_pulse_end", 8'(res_valid), 8'd0);
      check("t1_hold_ok",   8'(res_ok),    8'd1);
      check("t1_hold_len",  res_len,       8'd9);
      check("t1_idle_busy", 8'(busy),      8'd0);

      // Test 2: same data with a wrong CRC byte.
      for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 1'b0);
      send(8'hF5, 1'b1);
      check("t2_res_valid", 8'(res_valid), 8'd1);
      check("t2_res_ok",    8'(res_ok),    8'd0);
      check("t2_res_crc",   res_crc,       8'hF4);
      check("t2_err_count", err_count,     ERR_EN ? 8'd1 : 8'd0);

      // Test 3: a frame that contains only the CRC byte.
      step();
      send(8'h00, 1'b1);
      check("t3_res_valid", 8'(res_valid), 8'd1);
      check("t3_res_ok",    8'(res_ok),    8'd1);
      check("t3_res_len",   res_len,       8'd0);
      check("t3_res_crc",   res_crc,       8'h00);

      // Test 4: in_valid stays high; the ready gap after a data byte is 8 cycles.
      step();
      step();
      in_data  = 8'h01;
      in_last  = 1'b0;
      in_valid = 1'b1;
      check("t4_ready_pre", 8'(in_ready), 8'd1);
      step();
      in_data = 8'h07;
      in_last = 1'b1;
      lo = 0;
      while (!in_ready && lo < 20) begin
         lo++;
         step();
      end
      check("t4_ready_low", 8'(lo), 8'd8);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t4_res_valid", 8'(res_valid), 8'd1);
      check("t4_res_ok",    8'(res_ok),    8'd1);
      check("t4_res_crc",   res_crc,       8'h07);
      check("t4_res_len",   res_len,       8'd1);

      // Length saturation: 256 zero data bytes plus CRC 0x00 give len 255.
      for (int i = 0; i < 256; i++) send(8'h00, 1'b0);
      send(8'h00, 1'b1);
      check("sat_res_ok",  8'(res_ok), 8'd1);
      check("sat_res_len", res_len,    8'd255);
      check("sat_res_crc", res_crc,    8'h00);

      // Test 5: reset is pulsed in the middle of shifting the third byte.
      step();
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      send(8'h33, 1'b0);
      step();
      step();
      check("t5_mid_busy", 8'(busy), 8'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t5_in_ready",  8'(in_ready),  8'd1);
      check("t5_busy",      8'(busy),      8'd0);
      check("t5_res_valid", 8'(res_valid), 8'd0);
      check("t5_res_ok",    8'(res_ok),    8'd0);
      check("t5_res_len",   res_len,       8'd0);
      check("t5_res_crc",   res_crc,       8'd0);
      check("t5_err_count", err_count,     8'd0);
      step();
      check("t5_no_result", 8'(res_valid), 8'd0);
      send(8'h01, 1'b0);
      send(8'h07, 1'b1);
      check("t5_res_valid2", 8'(res_valid), 8'd1);
      check("t5_res_ok2",    8'(res_ok),    8'd1);
      check("t5_res_len2",   res_len,       8'd1);

      // Test 6: 300 back-to-back bad frames, then one good frame.
      for (int f = 0; f < 300; f++) begin
         send(8'h01, 1'b0);
         send(8'h00, 1'b1);
      end
      check("t6_last_ok",  8'(res_ok), 8'd0);
      check("t6_err_sat",  err_count,  ERR_EN ? 8'hFF : 8'h00);
      send(8'h01, 1'b0);
      send(8'h07, 1'b1);
      check("t6_good_ok",  8'(res_ok), 8'd1);
      check("t6_err_hold", err_count,  ERR_EN ? 8'hFF : 8'h00);

      step();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
